// File: rtl/sram_access_sequencer_if.sv
// ============================================================================
// Module  : sram_access_sequencer_if
// Brief   : Request/response handshake plus async-SRAM pin bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sram_access_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [NB-1:0]     req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              wr_done;

  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] SRAM_DQ_out;
  logic [DATA_W-1:0] SRAM_DQ_in;
  logic              SRAM_DQ_oe;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic [NB-1:0]     SRAM_BE_N;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, SRAM_DQ_in,
    input  req_ready, rsp_valid, rsp_rdata, wr_done,
    input  SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_CE_N, SRAM_OE_N,
    input  SRAM_WE_N, SRAM_BE_N
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, SRAM_DQ_in,
    output req_ready, rsp_valid, rsp_rdata, wr_done,
    output SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_CE_N, SRAM_OE_N,
    output SRAM_WE_N, SRAM_BE_N
  );
endinterface

`default_nettype wire

// File: rtl/sram_access_sequencer.sv
// ============================================================================
// Module  : sram_access_sequencer
// Brief   : Registered async-SRAM read/write sequencer with programmable waits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_access_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_STATES = 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              hold,
  sram_access_sequencer_if.slave bus
);
  localparam int         NB     = DATA_W / 8;
  localparam logic [3:0] c_wait = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_we, w_we_nxt;
  logic [NB-1:0]     r_be, w_be_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_dq_out, w_dq_out_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              r_dq_oe, w_dq_oe_nxt;
  logic              r_ce_n, w_ce_n_nxt;
  logic              r_oe_n, w_oe_n_nxt;
  logic              r_we_n, w_we_n_nxt;
  logic [NB-1:0]     r_be_n, w_be_n_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic              r_wr_done, w_wr_done_nxt;
  logic [DATA_W-1:0] w_rd_mask;
  logic              w_ready;
  logic              w_accept;

  // Ready is also gated by reset so nothing is offered while rst_n is low.
  assign w_ready  = (r_state == ST_IDLE) && !hold && rst_n;
  assign w_accept = w_ready && bus.req_valid;

  for (genvar i = 0; i < NB; i++) begin : g_mask
    assign w_rd_mask[8*i +: 8] = {8{r_be[i]}};
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_we_nxt        = r_we;
    w_be_nxt        = r_be;
    w_addr_nxt      = r_addr;
    w_dq_out_nxt    = r_dq_out;
    w_rdata_nxt     = r_rdata;
    w_dq_oe_nxt     = 1'b0;
    w_ce_n_nxt      = 1'b1;
    w_oe_n_nxt      = 1'b1;
    w_we_n_nxt      = 1'b1;
    w_be_n_nxt      = '1;
    w_rsp_valid_nxt = 1'b0;
    w_wr_done_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = ST_ACCESS;
          w_cnt_nxt    = c_wait;
          w_we_nxt     = bus.req_we;
          w_be_nxt     = bus.req_be;
          w_addr_nxt   = bus.req_addr;
          w_dq_out_nxt = bus.req_wdata;
          w_ce_n_nxt   = 1'b0;
          if (bus.req_we) begin
            w_we_n_nxt  = 1'b0;
            w_dq_oe_nxt = 1'b1;
            w_be_n_nxt  = ~bus.req_be;
          end else begin
            w_oe_n_nxt  = 1'b0;
            w_be_n_nxt  = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          // Strobes drop here; the write data keeps driving one more cycle for hold time.
          w_state_nxt = ST_RECOVER;
          w_dq_oe_nxt = r_we;
          if (r_we) begin
            w_wr_done_nxt = 1'b1;
          end else begin
            w_rsp_valid_nxt = 1'b1;
            w_rdata_nxt     = bus.SRAM_DQ_in & w_rd_mask;
          end
        end else begin
          w_cnt_nxt  = r_cnt - 4'd1;
          w_ce_n_nxt = 1'b0;
          if (r_we) begin
            w_we_n_nxt  = 1'b0;
            w_dq_oe_nxt = 1'b1;
            w_be_n_nxt  = ~r_be;
          end else begin
            w_oe_n_nxt  = 1'b0;
            w_be_n_nxt  = '0;
          end
        end
      end
      ST_RECOVER: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_dq_out    <= '0;
      r_rdata     <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_be_n      <= '1;
      r_rsp_valid <= 1'b0;
      r_wr_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_we        <= w_we_nxt;
      r_be        <= w_be_nxt;
      r_addr      <= w_addr_nxt;
      r_dq_out    <= w_dq_out_nxt;
      r_rdata     <= w_rdata_nxt;
      r_dq_oe     <= w_dq_oe_nxt;
      r_ce_n      <= w_ce_n_nxt;
      r_oe_n      <= w_oe_n_nxt;
      r_we_n      <= w_we_n_nxt;
      r_be_n      <= w_be_n_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_wr_done   <= w_wr_done_nxt;
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rdata;
  assign bus.wr_done     = r_wr_done;
  assign bus.SRAM_ADDR   = r_addr;
  assign bus.SRAM_DQ_out = r_dq_out;
  assign bus.SRAM_DQ_oe  = r_dq_oe;
  assign bus.SRAM_CE_N   = r_ce_n;
  assign bus.SRAM_OE_N   = r_oe_n;
  assign bus.SRAM_WE_N   = r_we_n;
  assign bus.SRAM_BE_N   = r_be_n;

endmodule

`default_nettype wire

// File: tb/tb_sram_access_sequencer.sv
// ============================================================================
// Module  : tb_sram_access_sequencer
// Brief   : Three sequencers (0, 1 and 3 wait states) driven in lockstep
//           against a timeline model and a simple async-SRAM device.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_access_sequencer;
  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        hold      = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [19:0] req_addr  = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be    = '0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sram_access_sequencer_if #(.DATA_W(16), .ADDR_W(20)) bus [3] ();

  logic [15:0] sram    [256];
  logic [15:0] ref_mem [256];

  logic [2:0]  w_ce_n, w_oe_n, w_we_n, w_oe, w_rsp, w_done, w_rdy;
  logic [1:0]  w_be_n   [3];
  logic [19:0] w_addr   [3];
  logic [15:0] w_dq_out [3];
  logic [15:0] w_rdata  [3];

  // Timeline model: each request occupies phases 0..W (access) and W+1 (recover).
  int          cyc = 0;
  int          m_acc    [3];
  logic        m_active [3];
  logic        m_we     [3];
  logic [1:0]  m_be     [3];
  logic [19:0] m_addr   [3];
  logic [15:0] m_wdata  [3];
  logic [15:0] m_rdata  [3];

  function automatic int ws(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  function automatic int ph(input int g);
    return cyc - m_acc[g];
  endfunction

  function automatic logic in_acc(input int g);
    return m_active[g] && ph(g) >= 0 && ph(g) <= ws(g);
  endfunction

  function automatic logic in_rec(input int g);
    return m_active[g] && ph(g) == ws(g) + 1;
  endfunction

  function automatic logic [15:0] mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [1:0] be);
    return (old & ~mask(be)) | (wd & mask(be));
  endfunction

  function automatic logic [15:0] init_word(input int i);
    if (i == 32'h12) return 16'h1234;
    return 16'(i * 257) ^ 16'h5AC3;
  endfunction

  function automatic logic [1:0] exp_be_n(input int g);
    if (!in_acc(g)) return 2'b11;
    return m_we[g] ? ~m_be[g] : 2'b00;
  endfunction

  task automatic chk(input int g, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h at t=%0t", g, name, act, exp, $time);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_access_sequencer #(
      .DATA_W(16), .ADDR_W(20), .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .bus(bus[g])
    );

    assign bus[g].req_valid  = req_valid;
    assign bus[g].req_we     = req_we;
    assign bus[g].req_addr   = req_addr;
    assign bus[g].req_wdata  = req_wdata;
    assign bus[g].req_be     = req_be;
    assign bus[g].SRAM_DQ_in = (!bus[g].SRAM_CE_N && !bus[g].SRAM_OE_N)
                               ? sram[bus[g].SRAM_ADDR[7:0]] : 16'hDEAD;

    assign w_ce_n[g]   = bus[g].SRAM_CE_N;
    assign w_oe_n[g]   = bus[g].SRAM_OE_N;
    assign w_we_n[g]   = bus[g].SRAM_WE_N;
    assign w_oe[g]     = bus[g].SRAM_DQ_oe;
    assign w_rsp[g]    = bus[g].rsp_valid;
    assign w_done[g]   = bus[g].wr_done;
    assign w_rdy[g]    = bus[g].req_ready;
    assign w_be_n[g]   = bus[g].SRAM_BE_N;
    assign w_addr[g]   = bus[g].SRAM_ADDR;
    assign w_dq_out[g] = bus[g].SRAM_DQ_out;
    assign w_rdata[g]  = bus[g].rsp_rdata;

    always @(negedge clk) begin
      #2;
      chk(g, "req_ready", 32'(bus[g].req_ready),
          32'(rst_n && !hold && !(in_acc(g) || in_rec(g))));
      chk(g, "ce_n", 32'(bus[g].SRAM_CE_N), 32'(!in_acc(g)));
      chk(g, "oe_n", 32'(bus[g].SRAM_OE_N), 32'(!(in_acc(g) && !m_we[g])));
      chk(g, "we_n", 32'(bus[g].SRAM_WE_N), 32'(!(in_acc(g) && m_we[g])));
      chk(g, "be_n", 32'(bus[g].SRAM_BE_N), 32'(exp_be_n(g)));
      chk(g, "dq_oe", 32'(bus[g].SRAM_DQ_oe), 32'((in_acc(g) || in_rec(g)) && m_we[g]));
      chk(g, "rsp_valid", 32'(bus[g].rsp_valid), 32'(in_rec(g) && !m_we[g]));
      chk(g, "wr_done", 32'(bus[g].wr_done), 32'(in_rec(g) && m_we[g]));
      chk(g, "rsp_rdata", 32'(bus[g].rsp_rdata), 32'(m_rdata[g]));
      chk(g, "sram_addr", 32'(bus[g].SRAM_ADDR), 32'(m_addr[g]));
      chk(g, "dq_out", 32'(bus[g].SRAM_DQ_out), 32'(m_wdata[g]));
      chk(g, "bus_contention", 32'(bus[g].SRAM_DQ_oe && !bus[g].SRAM_OE_N), 32'd0);
    end
  end

  // Model and SRAM device share one process so the memories have a single writer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        sram[i]    <= init_word(i);
        ref_mem[i] <= init_word(i);
      end
      for (int g = 0; g < 3; g++) begin
        m_active[g] <= 1'b0;
        m_we[g]     <= 1'b0;
        m_be[g]     <= '0;
        m_addr[g]   <= '0;
        m_wdata[g]  <= '0;
        m_rdata[g]  <= '0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int g = 0; g < 3; g++) begin
        if (!w_ce_n[g] && !w_we_n[g] && w_oe[g])
          sram[w_addr[g][7:0]] <= merge(sram[w_addr[g][7:0]], w_dq_out[g], ~w_be_n[g]);
        if (in_acc(g) && !m_we[g] && ph(g) == ws(g))
          m_rdata[g] <= ref_mem[m_addr[g][7:0]] & mask(m_be[g]);
        if (req_valid && !hold && !(in_acc(g) || in_rec(g))) begin
          m_active[g] <= 1'b1;
          m_acc[g]    <= cyc + 1;
          m_we[g]     <= req_we;
          m_be[g]     <= req_be;
          m_addr[g]   <= req_addr;
          m_wdata[g]  <= req_wdata;
          if (req_we)
            ref_mem[req_addr[7:0]] <= merge(ref_mem[req_addr[7:0]], req_wdata, req_be);
        end
      end
    end
  end

  int st_ce [3], st_we [3], st_oe [3], st_dqoe [3], st_be0 [3];
  int st_done [3], st_acc1 [3], st_acc2 [3];

  // Called at a falling edge; cycle 0 is the cycle the request is presented.
  task automatic observe(input int n, input int drop_at, input int hold_at, input int switch_at);
    for (int g = 0; g < 3; g++) begin
      st_ce[g] = 0; st_we[g] = 0; st_oe[g] = 0; st_dqoe[g] = 0; st_be0[g] = 0;
      st_done[g] = -1; st_acc1[g] = -1; st_acc2[g] = -1;
    end
    for (int i = 0; i < n; i++) begin
      if (i == drop_at)   req_valid = 1'b0;
      if (i == hold_at)   hold = 1'b1;
      if (i == switch_at) req_we = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) begin
        if (!w_ce_n[g]) st_ce[g]++;
        if (!w_we_n[g]) st_we[g]++;
        if (!w_oe_n[g]) st_oe[g]++;
        if (w_oe[g])    st_dqoe[g]++;
        if (!w_ce_n[g] && w_be_n[g] == 2'b00) st_be0[g]++;
        if ((w_rsp[g] || w_done[g]) && st_done[g] < 0) st_done[g] = i;
        if (w_rdy[g] && req_valid) begin
          if (st_acc1[g] < 0)      st_acc1[g] = i;
          else if (st_acc2[g] < 0) st_acc2[g] = i;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic we, input logic [19:0] addr, input logic [15:0] wd,
                       input logic [1:0] be);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    req_valid = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk(1, "ready_in_reset", 32'(w_rdy[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk(1, "ready_after_reset", 32'(w_rdy[1]), 32'd1);
    @(negedge clk);

    // Full-word write, 1 wait state on dut1
    issue(1'b1, 20'h0ABCD, 16'hBEEF, 2'b11);
    observe(8, 1, -1, -1);
    chk(1, "wr_we_cycles", 32'(st_we[1]), 32'd2);
    chk(1, "wr_ce_cycles", 32'(st_ce[1]), 32'd2);
    chk(1, "wr_be0_cycles", 32'(st_be0[1]), 32'd2);
    chk(1, "wr_dqoe_cycles", 32'(st_dqoe[1]), 32'd3);
    chk(1, "wr_done_at", 32'(st_done[1]), 32'd3);
    chk(1, "wr_dq_out", 32'(w_dq_out[1]), 32'hBEEF);
    chk(0, "ws0_ce_cycles", 32'(st_ce[0]), 32'd1);
    chk(0, "ws0_done_at", 32'(st_done[0]), 32'd2);
    chk(2, "ws3_ce_cycles", 32'(st_ce[2]), 32'd4);
    chk(2, "ws3_done_at", 32'(st_done[2]), 32'd5);

    // Masked read of a preloaded word
    issue(1'b0, 20'h00012, 16'h0000, 2'b01);
    observe(8, 1, -1, -1);
    chk(1, "rd_oe_cycles", 32'(st_oe[1]), 32'd2);
    chk(1, "rd_dqoe_cycles", 32'(st_dqoe[1]), 32'd0);
    chk(1, "rd_done_at", 32'(st_done[1]), 32'd3);
    chk(1, "rd_masked", 32'(w_rdata[1]), 32'h0034);
    chk(0, "ws0_rd_done_at", 32'(st_done[0]), 32'd2);
    chk(2, "ws3_rd_done_at", 32'(st_done[2]), 32'd5);

    // Read back the written word
    issue(1'b0, 20'h0ABCD, 16'h0000, 2'b11);
    observe(8, 1, -1, -1);
    chk(1, "rd_back", 32'(w_rdata[1]), 32'hBEEF);
    chk(2, "rd_back", 32'(w_rdata[2]), 32'hBEEF);

    // Zero byte-enable write still completes but changes nothing
    issue(1'b1, 20'h0ABCD, 16'h1111, 2'b00);
    observe(8, 1, -1, -1);
    chk(1, "be0_wr_done_at", 32'(st_done[1]), 32'd3);
    chk(1, "be0_wr_we_cycles", 32'(st_we[1]), 32'd2);

    // Upper-byte write then full read
    issue(1'b1, 20'h0ABCD, 16'h77AA, 2'b10);
    observe(8, 1, -1, -1);
    issue(1'b0, 20'h0ABCD, 16'h0000, 2'b11);
    observe(8, 1, -1, -1);
    chk(1, "partial_wr", 32'(w_rdata[1]), 32'h77EF);

    // Zero byte-enable read returns 0
    issue(1'b0, 20'h0ABCD, 16'h0000, 2'b00);
    observe(8, 1, -1, -1);
    chk(1, "be0_rd", 32'(w_rdata[1]), 32'h0000);
    chk(1, "be0_rd_done_at", 32'(st_done[1]), 32'd3);

    // Hold blocks acceptance entirely
    hold = 1'b1;
    issue(1'b1, 20'h00020, 16'h5555, 2'b11);
    observe(10, -1, -1, -1);
    req_valid = 1'b0;
    hold      = 1'b0;
    chk(1, "hold_ce_cycles", 32'(st_ce[1]), 32'd0);
    chk(1, "hold_accepts", 32'(st_acc1[1]), 32'hFFFF_FFFF);
    chk(2, "hold_ce_cycles", 32'(st_ce[2]), 32'd0);
    @(negedge clk);

    // Hold rising after acceptance does not disturb the access
    issue(1'b1, 20'h00030, 16'h3C3C, 2'b11);
    observe(8, 1, 1, -1);
    hold = 1'b0;
    chk(1, "hold_late_done_at", 32'(st_done[1]), 32'd3);
    chk(2, "hold_late_done_at", 32'(st_done[2]), 32'd5);

    // Back-to-back: write then read of the same word with valid held high
    issue(1'b1, 20'h00040, 16'hC0DE, 2'b11);
    observe(14, 7, -1, 1);
    chk(0, "b2b_second_accept", 32'(st_acc2[0]), 32'd3);
    chk(1, "b2b_second_accept", 32'(st_acc2[1]), 32'd4);
    chk(2, "b2b_second_accept", 32'(st_acc2[2]), 32'd6);
    chk(1, "b2b_rdata", 32'(w_rdata[1]), 32'hC0DE);
    chk(2, "b2b_rdata", 32'(w_rdata[2]), 32'hC0DE);

    // Asynchronous reset in the middle of a write access
    issue(1'b1, 20'h00050, 16'hAAAA, 2'b11);
    @(negedge clk);
    req_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk(1, "abort_ce_n", 32'(w_ce_n[1]), 32'd1);
    chk(1, "abort_we_n", 32'(w_we_n[1]), 32'd1);
    chk(1, "abort_dq_oe", 32'(w_oe[1]), 32'd0);
    chk(2, "abort_we_n", 32'(w_we_n[2]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk(1, "ready_after_abort", 32'(w_rdy[1]), 32'd1);
    @(negedge clk);
    observe(6, -1, -1, -1);
    chk(1, "abort_no_done", 32'(st_done[1]), 32'hFFFF_FFFF);
    chk(2, "abort_no_done", 32'(st_done[2]), 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
